dac_tx: RTL

Serial DAC transmitter: the output-direction counterpart of the scope's serial ADC capture path. It accepts a 12-bit sample over a valid/ready handshake and shifts a 16-bit frame (4 config bits + 12 data bits, MSB first) to an external SPI-style DAC. The frame format is MCP4921-compatible. It sits in the vga_clk domain and lets the design generate test waveforms that loop back into the ADC input.

---
 rtl/dac_tx_if.sv | 23 ++
 rtl/dac_tx.sv | 136 +++++++++++++
 2 files changed

// File: rtl/dac_tx_if.sv
// rtl/dac_tx_if.sv - sample handshake bundle between a waveform source and dac_tx
interface dac_tx_if;
  logic        valid;
  logic        ready;
  logic [11:0] data;
  logic        done;

  // Source side: offers samples and watches for frame completion.
  modport master (
    output valid,
    output data,
    input  ready,
    input  done
  );

  // Transmitter side: accepts samples and reports frame completion.
  modport slave (
    input  valid,
    input  data,
    output ready,
    output done
  );
endinterface

// File: rtl/dac_tx.sv
// rtl/dac_tx.sv - serial DAC transmitter, 16-bit MCP4921-style frames; optional LDAC strobe with DAC_TX_LDAC_EN
module dac_tx #(
  parameter int          CLK_DIV = 2,
  parameter logic [3:0]  CONFIG  = 4'b0011
) (
  input  logic     clk,
  input  logic     reset,
  dac_tx_if.slave  bus,
  output logic     dac_clk,
  output logic     dac_cs,
  output logic     dac_sd
`ifdef DAC_TX_LDAC_EN
  ,
  output logic     dac_ldac
`endif
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

`ifdef DAC_TX_LDAC_EN
  typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_HOLD, S_GAP, S_LDAC} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_HOLD, S_GAP} state_t;
`endif

  state_t      state;
  logic [7:0]  phase;
  logic [3:0]  bit_cnt;
  // Bit 15 of the frame goes straight onto dac_sd at acceptance, so only
  // the remaining 15 bits need to be held for shifting.
  logic [14:0] shreg;

  // Frame sequencer: every output is registered so dac_clk/dac_cs/dac_sd are glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      phase     <= 8'd0;
      bit_cnt   <= 4'd0;
      shreg     <= 15'd0;
      bus.ready <= 1'b1;
      bus.done  <= 1'b0;
      dac_clk   <= 1'b0;
      dac_cs    <= 1'b1;
      dac_sd    <= 1'b0;
`ifdef DAC_TX_LDAC_EN
      dac_ldac  <= 1'b1;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.valid && bus.ready) begin
            shreg     <= {CONFIG[2:0], bus.data};
            bit_cnt   <= 4'd15;
            bus.ready <= 1'b0;
            dac_cs    <= 1'b0;
            dac_sd    <= CONFIG[3];
            phase     <= RELOAD;
            state     <= S_LOW;
          end
        end
        S_LOW: begin
          if (phase == 8'd0) begin
            dac_clk <= 1'b1;
            phase   <= RELOAD;
            state   <= S_HIGH;
          end else begin
            phase <= phase - 8'd1;
          end
        end
        S_HIGH: begin
          if (phase == 8'd0) begin
            // Data only moves on the falling edge so the DAC sees it stable at the next rise.
            dac_clk <= 1'b0;
            phase   <= RELOAD;
            if (bit_cnt == 4'd0) begin
              state <= S_HOLD;
            end else begin
              bit_cnt <= bit_cnt - 4'd1;
              dac_sd  <= shreg[14];
              shreg   <= {shreg[13:0], 1'b0};
              state   <= S_LOW;
            end
          end else begin
            phase <= phase - 8'd1;
          end
        end
        S_HOLD: begin
          if (phase == 8'd0) begin
            dac_cs   <= 1'b1;
            dac_sd   <= 1'b0;
            bus.done <= 1'b1;
            phase    <= RELOAD;
            state    <= S_GAP;
          end else begin
            phase <= phase - 8'd1;
          end
        end
        S_GAP: begin
          if (phase == 8'd0) begin
`ifdef DAC_TX_LDAC_EN
            dac_ldac <= 1'b0;
            phase    <= RELOAD;
            state    <= S_LDAC;
`else
            bus.ready <= 1'b1;
            state     <= S_IDLE;
`endif
          end else begin
            phase <= phase - 8'd1;
          end
        end
`ifdef DAC_TX_LDAC_EN
        S_LDAC: begin
          // First half drives the strobe low, second half is recovery with it high.
          if (phase == 8'd0) begin
            if (!dac_ldac) begin
              dac_ldac <= 1'b1;
              phase    <= RELOAD;
            end else begin
              bus.ready <= 1'b1;
              state     <= S_IDLE;
            end
          end else begin
            phase <= phase - 8'd1;
          end
        end
`endif
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
